// File: rtl/dac_dac8830_if.sv
// OPB-mapped playback engine for a DAC8830-class 16-bit serial DAC.
// Software fills the sample RAM and sets LEN/RATE; each frame shifts one word out MSB first.
module dac_dac8830_if #(
    parameter int CLK_DIV  = 2,
    parameter int RAM_AW   = 9,
    parameter int RATE_RST = 200
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic [31:0] OPB_DI,
    input  logic [31:0] OPB_ADDR,
    input  logic        OPB_RE,
    input  logic        OPB_WE,
    output logic [31:0] OPB_DO,
    output logic        DA_CS_N,
    output logic        DA_SCLK,
    output logic        DA_SDIN
);

    localparam int                DEPTH    = 1 << RAM_AW;
    localparam logic [RAM_AW:0]   LEN_MAX  = (RAM_AW + 1)'(DEPTH);
    localparam logic [16:0]       MIN_PER  = 17'(36 * CLK_DIV + 1);
    localparam logic [15:0]       DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t state, state_n;

    logic [15:0]       mem [DEPTH];
    logic [RAM_AW-1:0] ram_raddr;
    logic [15:0]       ram_rdata;

    logic [RAM_AW-1:0] idx;
    logic [RAM_AW:0]   len;
    logic [15:0]       rate;
    logic              loop_en;
    logic              done;
    logic              abort_pend;
    logic [15:0]       shreg;
    logic [15:0]       div_cnt;
    logic [4:0]        half_cnt;
    logic [16:0]       frame_cnt;
    logic [16:0]       eff_per;

    logic        busy, is_ram, wr_ram, wr_ctrl, wr_len, wr_rate;
    logic        start_ok, abort_req, half_done, more, period_hit, in_frame;
    logic [31:0] status, reg_rdata;
    logic        unused_addr;

    assign unused_addr = ^OPB_ADDR[31:12];

    always_comb begin
        busy      = (state != S_IDLE);
        is_ram    = ~OPB_ADDR[11];
        wr_ram    = OPB_WE & is_ram;
        wr_ctrl   = OPB_WE & (OPB_ADDR[11:0] == 12'h800);
        wr_len    = OPB_WE & (OPB_ADDR[11:0] == 12'h804);
        wr_rate   = OPB_WE & (OPB_ADDR[11:0] == 12'h80C);
        start_ok  = wr_ctrl & OPB_DI[0] & ~busy & (len != '0);
        abort_req = wr_ctrl & OPB_DI[2] & busy;
        half_done = (div_cnt == DIV_LAST);
        in_frame  = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
        more      = (({1'b0, idx} + (RAM_AW + 1)'(1)) < len);
        eff_per   = ({1'b0, rate} < MIN_PER) ? MIN_PER : {1'b0, rate};
        // frame_cnt is 0 in the first SETUP cycle; leaving GAP at P-2 puts the next SETUP at P
        period_hit = ((frame_cnt + 17'd2) >= eff_per);
        // engine owns the single read port during LOAD
        ram_raddr = (state == S_LOAD) ? idx : OPB_ADDR[RAM_AW+1:2];
        ram_rdata = mem[ram_raddr];
    end

    always_comb begin
        status                 = '0;
        status[0]              = busy;
        status[1]              = done;
        status[16 +: RAM_AW]   = idx;
        case (OPB_ADDR[11:0])
            12'h800: reg_rdata = {30'b0, loop_en, 1'b0};
            12'h804: reg_rdata = 32'(len);
            12'h808: reg_rdata = status;
            12'h80C: reg_rdata = {16'b0, rate};
            default: reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_ok) state_n = S_LOAD;
            S_LOAD:  state_n = S_SETUP;
            S_SETUP: if (half_done) state_n = S_SHIFT;
            S_SHIFT: if (half_done && half_cnt == 5'd31) state_n = S_HOLD;
            S_HOLD:  if (half_done) state_n = S_GAP;
            S_GAP: begin
                if (abort_pend)
                    state_n = S_IDLE;
                else if (period_hit)
                    state_n = (more || loop_en) ? S_LOAD : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge OPB_CLK) begin
        if (wr_ram)
            mem[OPB_ADDR[RAM_AW+1:2]] <= OPB_DI[15:0];
    end

    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            state      <= S_IDLE;
            idx        <= '0;
            len        <= '0;
            rate       <= 16'(RATE_RST);
            loop_en    <= 1'b0;
            done       <= 1'b0;
            abort_pend <= 1'b0;
            shreg      <= '0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            frame_cnt  <= '0;
            DA_CS_N    <= 1'b1;
            DA_SCLK    <= 1'b0;
            DA_SDIN    <= 1'b0;
            OPB_DO     <= '0;
        end else begin
            state <= state_n;

            if (wr_ctrl)
                loop_en <= OPB_DI[1];
            if (wr_len && !busy)
                len <= (OPB_DI > 32'(DEPTH)) ? LEN_MAX : OPB_DI[RAM_AW:0];
            if (wr_rate && !busy)
                rate <= OPB_DI[15:0];

            abort_pend <= (state_n != S_IDLE) && (abort_pend || abort_req);

            if (start_ok) begin
                done <= 1'b0;
                idx  <= '0;
            end else if (state == S_GAP && state_n == S_LOAD) begin
                idx <= more ? idx + RAM_AW'(1) : '0;
            end else if (state == S_GAP && state_n == S_IDLE) begin
                done <= 1'b1;
            end

            div_cnt <= (in_frame && !half_done) ? div_cnt + 16'd1 : '0;

            if (state != S_SHIFT)
                half_cnt <= '0;
            else if (half_done)
                half_cnt <= half_cnt + 5'd1;

            frame_cnt <= (state == S_LOAD) ? '0 : frame_cnt + 17'd1;

            // even half_cnt is SCLK high; its end is the falling edge
            if (state == S_LOAD)
                shreg <= ram_rdata;
            else if (state == S_SHIFT && half_done && !half_cnt[0])
                shreg <= {shreg[14:0], 1'b0};

            DA_CS_N <= ~in_frame;
            DA_SCLK <= (state == S_SHIFT) && !half_cnt[0];
            DA_SDIN <= in_frame && shreg[15];

            if (!OPB_RE)
                OPB_DO <= '0;
            else if (!is_ram)
                OPB_DO <= reg_rdata;
            else if (state != S_LOAD)
                OPB_DO <= {16'b0, ram_rdata};
        end
    end

endmodule

// File: tb/tb_dac_dac8830_if.sv
// Scoreboard bench for dac_dac8830_if: a DAC capture model pops expected frames
// on every CS rising edge; register reads are checked inline.
module tb_dac_dac8830_if;

    localparam logic [31:0] A_CTRL   = 32'h800;
    localparam logic [31:0] A_LEN    = 32'h804;
    localparam logic [31:0] A_STATUS = 32'h808;
    localparam logic [31:0] A_RATE   = 32'h80C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] di, addr, do_;
    logic        re, we;
    logic        cs_n, sclk, sdin;

    always #20 clk = ~clk;

    dac_dac8830_if #(.CLK_DIV(2), .RAM_AW(9), .RATE_RST(200)) dut (
        .OPB_CLK (clk),
        .OPB_RST (rst),
        .OPB_DI  (di),
        .OPB_ADDR(addr),
        .OPB_RE  (re),
        .OPB_WE  (we),
        .OPB_DO  (do_),
        .DA_CS_N (cs_n),
        .DA_SCLK (sclk),
        .DA_SDIN (sdin)
    );

    typedef struct {
        logic [15:0] word;
        int          space;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   wr_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // DAC capture model
    logic        p_cs = 1'b1;
    logic        p_sclk = 1'b0;
    int          fall_cyc = 0;
    int          space = 0;
    int          frames_started = 0;
    int          bits = 0;
    logic [15:0] cap = '0;
    bit          skip_frame = 0;

    always @(negedge clk) begin
        exp_t e;
        if (p_cs && !cs_n) begin
            space = cyc - fall_cyc;
            fall_cyc = cyc;
            frames_started++;
            bits = 0;
            cap = '0;
        end
        if (!cs_n && sclk && !p_sclk) begin
            cap = {cap[14:0], sdin};
            bits++;
        end
        if (!p_cs && cs_n) begin
            if (skip_frame) begin
                skip_frame = 0;
            end else if (sb.size() == 0) begin
                chk("frame_expected", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("dac_word", {16'b0, cap}, {16'b0, e.word});
                chk("sclk_pulses", bits, 16);
                chk("cs_low_width", cyc - fall_cyc, 68);
                if (e.space != 0)
                    chk("frame_spacing", space, e.space);
            end
        end
        p_cs = cs_n;
        p_sclk = sclk;
    end

    task automatic push(input logic [15:0] w, input int sp);
        exp_t e;
        e.word = w;
        e.space = sp;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        di = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        wr_cyc = cyc;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        re = 1'b1;
        @(negedge clk);
        @(negedge clk);
        d = do_;
        re = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        s = 32'h1;
        for (int k = 0; k < 3000 && s[0]; k++)
            rd(A_STATUS, s);
        chk("wait_idle", {31'b0, s[0]}, 32'd0);
    endtask

    task automatic wait_frames(input int target);
        int k;
        k = 0;
        while (frames_started < target && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_frame", {31'b0, frames_started >= target}, 32'd1);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          base;
        int          start_cyc;

        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; di = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'b0, cs_n}, 32'd1);
        chk("rst_sclk", {31'b0, sclk}, 32'd0);
        chk("rst_sdin", {31'b0, sdin}, 32'd0);
        chk("rst_opb_do", do_, 32'd0);
        rst = 1'b0;

        rd(A_STATUS, r); chk("rst_status", r, 32'h0);
        rd(A_RATE, r);   chk("rst_rate", r, 32'd200);
        rd(A_LEN, r);    chk("rst_len", r, 32'd0);
        rd(A_CTRL, r);   chk("rst_ctrl", r, 32'd0);
        wr(32'h810, 32'hDEAD_BEEF);
        rd(32'h810, r);  chk("unmapped_read", r, 32'd0);
        wr(A_LEN, 32'd1000);
        rd(A_LEN, r);    chk("len_saturate", r, 32'd512);

        // single-shot
        wr(32'h000, 32'h0000_A5C3);
        wr(A_LEN, 32'd1);
        wr(A_RATE, 32'd200);
        push(16'hA5C3, 0);
        wr(A_CTRL, 32'h1);
        start_cyc = wr_cyc;
        wait_idle();
        chk("start_to_cs_fall", fall_cyc - start_cyc, 2);
        rd(A_STATUS, r);  chk("single_status", r, 32'h2);
        rd(32'h000, r);   chk("ram0_read", r, 32'hA5C3);

        // multi-sample
        wr(32'h000, 32'h0000);
        wr(32'h004, 32'hFFFF);
        wr(32'h008, 32'h8001);
        wr(32'h00C, 32'h7FFE);
        wr(A_LEN, 32'd4);
        wr(A_RATE, 32'd100);
        push(16'h0000, 0);
        push(16'hFFFF, 100);
        push(16'h8001, 100);
        push(16'h7FFE, 100);
        wr(A_CTRL, 32'h1);
        wait_idle();
        rd(A_STATUS, r);  chk("multi_status", r, 32'h0003_0002);

        // rate clamp
        wr(A_LEN, 32'd2);
        wr(A_RATE, 32'd10);
        rd(A_RATE, r);    chk("rate_readback", r, 32'd10);
        push(16'h0000, 0);
        push(16'hFFFF, 73);
        wr(A_CTRL, 32'h1);
        wait_idle();

        // loop, then abort during the 7th frame
        wr(A_LEN, 32'd3);
        wr(A_RATE, 32'd100);
        push(16'h0000, 0);
        push(16'hFFFF, 100);
        push(16'h8001, 100);
        push(16'h0000, 100);
        push(16'hFFFF, 100);
        push(16'h8001, 100);
        push(16'h0000, 100);
        wr(A_CTRL, 32'h2);
        base = frames_started;
        wr(A_CTRL, 32'h3);
        rd(A_CTRL, r);    chk("ctrl_loop_read", r, 32'h2);
        wait_frames(base + 7);
        repeat (20) @(negedge clk);
        wr(A_CTRL, 32'h6);
        wait_idle();
        repeat (300) @(negedge clk);
        chk("abort_frame_count", frames_started - base, 7);
        rd(A_STATUS, r);  chk("abort_status", r, 32'h2);
        wr(A_CTRL, 32'h0);

        // ignored writes; START+ABORT while idle starts playback
        wr(32'h000, 32'h1111);
        wr(32'h004, 32'h2222);
        wr(A_LEN, 32'd2);
        wr(A_RATE, 32'd200);
        push(16'h1111, 0);
        push(16'h2222, 200);
        base = frames_started;
        wr(A_CTRL, 32'h5);
        wait_frames(base + 1);
        wr(A_LEN, 32'd5);
        wr(A_CTRL, 32'h1);
        rd(A_LEN, r);     chk("len_busy_ignored", r, 32'd2);
        wait_idle();
        chk("no_restart_frames", frames_started - base, 2);
        rd(A_STATUS, r);  chk("ignored_status", r, 32'h0001_0002);
        wr(A_LEN, 32'd0);
        wr(A_CTRL, 32'h1);
        repeat (150) @(negedge clk);
        chk("len0_no_frame", frames_started - base, 2);
        rd(A_STATUS, r);  chk("len0_status", r, 32'h0001_0002);

        // reset mid-frame
        wr(32'h000, 32'h1234);
        wr(A_LEN, 32'd1);
        base = frames_started;
        wr(A_CTRL, 32'h1);
        wait_frames(base + 1);
        repeat (10) @(negedge clk);
        skip_frame = 1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n", {31'b0, cs_n}, 32'd1);
        chk("midrst_sclk", {31'b0, sclk}, 32'd0);
        chk("midrst_sdin", {31'b0, sdin}, 32'd0);
        rst = 1'b0;
        rd(A_STATUS, r);  chk("midrst_status", r, 32'h0);
        rd(32'h000, r);   chk("midrst_ram0", r, 32'h1234);
        rd(A_LEN, r);     chk("midrst_len", r, 32'd0);
        repeat (100) @(negedge clk);
        chk("midrst_no_frame", frames_started - base, 1);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
